mips_datapath_fetch_queue: RTL
==============================

# mips_datapath_fetch_queue

Instruction fetch queue between the PC datapath and the decode stage. It issues instruction-memory read requests at the current PC and tells the PC to step on each accepted request. In-order memory responses are buffered together with their fetch address and handed to decode over a valid/ready handshake. A redirect flushes the queue and silently discards responses still in flight.

## Interface
Parameters:
- DEPTH, 4, total entries (allocated + in flight + dropped); power of two, ≥2
- ADDR_W, 32, address width
- DATA_W, 32, instruction width

Ports:
- ctrl.clk  input  1  clock; rising edge
- ctrl.rst  input  1  reset; asynchronous, active-high
- pcAddr  input  ADDR_W  current PC (addrCurr of PC datapath)
- pcStep  output  1  request accepted this cycle; PC advances
- flush  input  1  redirect; discard all queued and in-flight work
- reqValid  output  1  memory read request valid
- reqReady  input  1  memory accepts request
- reqAddr  output  ADDR_W  request address, equals pcAddr
- rspValid  input  1  memory response valid; always accepted, in request order
- rspData  input  DATA_W  fetched instruction
- outValid  output  1  entry available to decode
- outReady  input  1  decode consumes entry
- outInstr  output  DATA_W  instruction at head
- outAddr  output  ADDR_W  fetch address of head instruction
- level  output  clog2(DEPTH)+1  occupancy: (tail−head) + dropCnt

## Operation
- Ring of DEPTH entries {addr, instr}; pointers tail (allocate), fill (next response), head (next output), each clog2(DEPTH)+1 bits with a wrap bit; dropCnt counts in-flight responses to discard.
- reqValid = !flush && level < DEPTH. On reqValid && reqReady: entry[tail].addr <= pcAddr, tail++, pcStep = 1.
- Response: if dropCnt ≠ 0, dropCnt−− and data discarded; otherwise entry[fill].instr <= rspData, fill++.
- outValid = !flush && head ≠ fill; outInstr/outAddr from entry[head]. On outValid && outReady: head++.
- Flush: head <= tail, fill <= tail, dropCnt <= dropCnt + (tail − fill) − (response this cycle ? 1 : 0); no request, no output, no fill this cycle.
- Full: level == DEPTH → reqValid low; pcStep low. Empty: head == fill → outValid low.
- Response with tail == fill and dropCnt == 0 is a protocol error; ignored.
- Pointer wrap: modular arithmetic on the full width; wrap bit distinguishes full from empty.

## Timing
- Reset: tail = fill = head = 0, dropCnt = 0; reqValid = 1 (no flush), pcStep = 0, outValid = 0, level = 0, outInstr/outAddr = 0.
- Reset mid-operation clears all state immediately; memory shares ctrl.rst, so no post-reset responses are expected.
- Request accepted cycle N → response earliest N+1 → outValid in the cycle after the response (no bypass).
- Throughput: one request, one response, one output per cycle sustained when DEPTH ≥ memory latency + 1.
- Simultaneous request+response+output in one cycle: all three take effect; level changes by +1 (request) −1 (output).
- Flush with rspValid: that response counts as dropped.

## Configuration
- MIPS_DATAPATH_FETCH_QUEUE_BYPASS_EN defined: when head == fill, dropCnt == 0, rspValid and !flush, outValid = 1 with outInstr = rspData and outAddr = entry[fill].addr in the same cycle. If outReady, head and fill both advance. Output latency 0.
- Undefined: outputs come from registered entries only; output latency 1.

## Structure
- Shared package: entry typedef {addr, instr}, pointer-width constant clog2(DEPTH)+1, request/response/output handshake bundle typedefs under Mips/Datapath/Fetch.
- One sub-module: mips_datapath_fetch_ring holds the storage array. It has one write port for addr at tail, one write port for instr at fill, and one read port at head. Pointer and drop logic stay in the top.

## Test plan
- Reset, pcAddr=0x00400000, reqReady=1, memory latency 1, outReady=1 → pcStep each cycle; outAddr 0x00400000, 0x00400004, … in order, first outValid 2 cycles after first request.
- outReady=0, DEPTH=4 → exactly 4 requests accepted; reqValid low; level=4; release outReady → 4 outputs then requests resume.
- Memory latency 3, 3 requests outstanding, flush → no outputs for those 3 responses; dropCnt 3→0; next request at new pcAddr=0x00400100 returns first.
- Flush in same cycle as a response with 2 in flight → dropCnt=1; only the following response dropped.
- Pointer wrap: 10 back-to-back fetches through DEPTH=4 with random outReady → all addresses delivered once, in order, no loss or duplicate.
- BYPASS_EN, empty queue, response at cycle N → outValid and outInstr=rspData in cycle N; without macro, at N+1.

Source files
------------

// File: rtl/mips_datapath_fetch_queue_pkg.sv
// Shared types and helpers for the instruction fetch queue (Mips/Datapath/Fetch).
// Optional feature macro: MIPS_DATAPATH_FETCH_QUEUE_BYPASS_EN.
package mips_datapath_fetch_queue_pkg;

  localparam int unsigned FQ_DEPTH  = 4;
  localparam int unsigned FQ_ADDR_W = 32;
  localparam int unsigned FQ_DATA_W = 32;

  // Pointers carry one extra wrap bit so that full and empty are distinguishable.
  function automatic int unsigned fq_ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int unsigned FQ_PTR_W = fq_ptr_w(FQ_DEPTH);

  typedef struct packed {
    logic [FQ_ADDR_W-1:0] addr;
    logic [FQ_DATA_W-1:0] instr;
  } fq_entry_t;

  typedef struct packed {
    logic                 valid;
    logic [FQ_ADDR_W-1:0] addr;
  } fq_req_t;

  typedef struct packed {
    logic                 valid;
    logic [FQ_DATA_W-1:0] data;
  } fq_rsp_t;

  typedef struct packed {
    logic                 valid;
    logic [FQ_ADDR_W-1:0] addr;
    logic [FQ_DATA_W-1:0] instr;
  } fq_out_t;

endpackage

// File: rtl/mips_datapath_fetch_ring.sv
// Fetch-queue storage: addr written at tail, instr written at fill, both read at head.
module mips_datapath_fetch_ring
  import mips_datapath_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = FQ_DEPTH,
  parameter int unsigned ADDR_W = FQ_ADDR_W,
  parameter int unsigned DATA_W = FQ_DATA_W
) (
  input  logic                       clk,
  input  logic                       addr_we,
  input  logic [$clog2(DEPTH)-1:0]   addr_idx,
  input  logic [ADDR_W-1:0]          addr_wdata,
  input  logic                       instr_we,
  input  logic [$clog2(DEPTH)-1:0]   instr_idx,
  input  logic [DATA_W-1:0]          instr_wdata,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [ADDR_W-1:0]          rd_addr,
  output logic [DATA_W-1:0]          rd_instr
);

  logic [ADDR_W-1:0] addr_mem  [DEPTH];
  logic [DATA_W-1:0] instr_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (addr_we)  addr_mem[addr_idx]   <= addr_wdata;
    if (instr_we) instr_mem[instr_idx] <= instr_wdata;
  end

  always_comb begin
    rd_addr  = addr_mem[rd_idx];
    rd_instr = instr_mem[rd_idx];
  end

endmodule

// File: rtl/mips_datapath_fetch_queue.sv
// Instruction fetch queue between PC datapath and decode; flush drops in-flight responses.
// Optional MIPS_DATAPATH_FETCH_QUEUE_BYPASS_EN: zero-latency response-to-output when empty.
module mips_datapath_fetch_queue
  import mips_datapath_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = FQ_DEPTH,
  parameter int unsigned ADDR_W = FQ_ADDR_W,
  parameter int unsigned DATA_W = FQ_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        pcAddr,
  output logic                     pcStep,
  input  logic                     flush,
  output logic                     reqValid,
  input  logic                     reqReady,
  output logic [ADDR_W-1:0]        reqAddr,
  input  logic                     rspValid,
  input  logic [DATA_W-1:0]        rspData,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [DATA_W-1:0]        outInstr,
  output logic [ADDR_W-1:0]        outAddr,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PW = fq_ptr_w(DEPTH);
  localparam int unsigned IW = PW - 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic [PW-1:0]     tail_q, tail_d, fill_q, fill_d, head_q, head_d, drop_q, drop_d;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_instr;
  logic              req_fire, rsp_live, rsp_fill, out_fire, have_entry, bypass;

  always_comb begin
    level      = (tail_q - head_q) + drop_q;
    reqValid   = !flush && (level < DEPTH_P);
    reqAddr    = pcAddr;
    req_fire   = reqValid && reqReady;
    pcStep     = req_fire;
    // A response with nothing outstanding and nothing to drop is a protocol error.
    rsp_live   = rspValid && ((drop_q != '0) || (tail_q != fill_q));
    rsp_fill   = rsp_live && (drop_q == '0) && !flush;
    have_entry = (head_q != fill_q);
`ifdef MIPS_DATAPATH_FETCH_QUEUE_BYPASS_EN
    bypass     = !have_entry && rsp_fill;
`else
    bypass     = 1'b0;
`endif
    outValid   = !flush && (have_entry || bypass);
    outInstr   = !outValid ? '0 : (have_entry ? head_instr : rspData);
    // During bypass head == fill, so the head read port already holds entry[fill].addr.
    outAddr    = outValid ? head_addr : '0;
    out_fire   = outValid && outReady;

    tail_d = tail_q;
    fill_d = fill_q;
    head_d = head_q;
    drop_d = drop_q;
    if (flush) begin
      head_d = tail_q;
      fill_d = tail_q;
      drop_d = drop_q + (tail_q - fill_q) - (rsp_live ? PTR_ONE : '0);
    end else begin
      if (req_fire)                   tail_d = tail_q + PTR_ONE;
      if (rsp_live && drop_q != '0)   drop_d = drop_q - PTR_ONE;
      if (rsp_fill)                   fill_d = fill_q + PTR_ONE;
      if (out_fire)                   head_d = head_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tail_q <= '0;
      fill_q <= '0;
      head_q <= '0;
      drop_q <= '0;
    end else begin
      tail_q <= tail_d;
      fill_q <= fill_d;
      head_q <= head_d;
      drop_q <= drop_d;
    end
  end

  mips_datapath_fetch_ring #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ring (
    .clk         (clk),
    .addr_we     (req_fire),
    .addr_idx    (tail_q[IW-1:0]),
    .addr_wdata  (pcAddr),
    .instr_we    (rsp_fill),
    .instr_idx   (fill_q[IW-1:0]),
    .instr_wdata (rspData),
    .rd_idx      (head_q[IW-1:0]),
    .rd_addr     (head_addr),
    .rd_instr    (head_instr)
  );

endmodule
